// File: rtl/stack_pkg.sv
// Shared definitions for the stack operation sequencer: default sizes,
// opcode and FSM state encodings, and opcode classification.
package stack_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_STK_DEPTH = 32;
  localparam int DEPTH_W       = 6;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_PUSHI = 3'b001,
    OP_POP   = 3'b010,
    OP_TOS   = 3'b011,
    OP_ADD   = 3'b100,
    OP_SUB   = 3'b101,
    OP_AND   = 3'b110,
    OP_NOT   = 3'b111
  } op_e;

  // REPORT is part of the shared encoding; this sequencer reports results
  // from IDLE, so it only ever sees REPORT through the recovery branch.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_STROBE1 = 3'd1,
    S_CAP1    = 3'd2,
    S_STROBE2 = 3'd3,
    S_CAP2    = 3'd4,
    S_PUSH_R  = 3'd5,
    S_REPORT  = 3'd6
  } state_e;

  function automatic logic is_binary(input op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  endfunction

endpackage

// File: rtl/stack_alu.sv
// Combinational result unit: B op A for the binary opcodes, ~A for NOT,
// all wrapping modulo 2^DATA_W.
module stack_alu
  import stack_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  op_e               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    result = '0;
    case (op)
      OP_ADD:  result = b + a;
      OP_SUB:  result = b - a;
      OP_AND:  result = b & a;
      OP_NOT:  result = ~a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/stack_op_sequencer.sv
// Sequencer that turns accepted stack opcodes into push/pop/tos strobe
// sequences for an external stack, tracking depth and a sticky error flag.
module stack_op_sequencer
  import stack_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int STK_DEPTH = DEF_STK_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               op_valid,
  input  logic [2:0]         op_code,
  input  logic [DATA_W-1:0]  op_imm,
  output logic               op_ready,
  output logic               push,
  output logic               pop,
  output logic               tos,
  output logic [DATA_W-1:0]  stk_din,
  input  logic [DATA_W-1:0]  stk_res,
  output logic               res_valid,
  output logic [DATA_W-1:0]  res_data,
  output logic               err,
  output logic [DEPTH_W-1:0] depth
);

  localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(STK_DEPTH);
  localparam logic [DEPTH_W-1:0] ONE  = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] TWO  = DEPTH_W'(2);

  state_e            state;
  op_e               op_q;
  op_e               op_in;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_res;

  assign op_in = op_e'(op_code);

  // NOT operates on the value arriving now; binary ops use the captured top as A.
  assign alu_a = (state == S_CAP1) ? stk_res : a_q;

  stack_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op_q),
    .a      (alu_a),
    .b      (stk_res),
    .result (alu_res)
  );

  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= OP_NOP;
      a_q       <= '0;
      op_ready  <= 1'b1;
      push      <= 1'b0;
      pop       <= 1'b0;
      tos       <= 1'b0;
      stk_din   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      err       <= 1'b0;
      depth     <= '0;
    end else begin
      push      <= 1'b0;
      pop       <= 1'b0;
      tos       <= 1'b0;
      res_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (op_valid && op_ready) begin
            op_q <= op_in;
            case (op_in)
              OP_NOP: ;
              OP_PUSHI: begin
                if (depth == FULL) begin
                  err <= 1'b1;
                end else begin
                  push     <= 1'b1;
                  stk_din  <= op_imm;
                  depth    <= depth + ONE;
                  state    <= S_STROBE1;
                  op_ready <= 1'b0;
                end
              end
              OP_POP, OP_TOS, OP_NOT: begin
                if (depth == '0) begin
                  err <= 1'b1;
                end else begin
                  tos      <= (op_in == OP_TOS);
                  pop      <= (op_in != OP_TOS);
                  depth    <= (op_in == OP_TOS) ? depth : depth - ONE;
                  state    <= S_STROBE1;
                  op_ready <= 1'b0;
                end
              end
              default: begin
                if (depth < TWO) begin
                  err <= 1'b1;
                end else begin
                  pop      <= 1'b1;
                  depth    <= depth - ONE;
                  state    <= S_STROBE1;
                  op_ready <= 1'b0;
                end
              end
            endcase
          end
        end

        S_STROBE1: begin
          if (op_q == OP_PUSHI) begin
            state    <= S_IDLE;
            op_ready <= 1'b1;
          end else begin
            state <= S_CAP1;
          end
        end

        S_CAP1: begin
          if (op_q == OP_NOT) begin
            push    <= 1'b1;
            stk_din <= alu_res;
            depth   <= depth + ONE;
            state   <= S_PUSH_R;
          end else if (is_binary(op_q)) begin
            a_q   <= stk_res;
            pop   <= 1'b1;
            depth <= depth - ONE;
            state <= S_STROBE2;
          end else begin
            res_valid <= 1'b1;
            res_data  <= stk_res;
            state     <= S_IDLE;
            op_ready  <= 1'b1;
          end
        end

        S_STROBE2: state <= S_CAP2;

        S_CAP2: begin
          push    <= 1'b1;
          stk_din <= alu_res;
          depth   <= depth + ONE;
          state   <= S_PUSH_R;
        end

        S_PUSH_R: begin
          res_valid <= 1'b1;
          res_data  <= stk_din;
          state     <= S_IDLE;
          op_ready  <= 1'b1;
        end

        default: begin
          state    <= S_IDLE;
          op_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Self-checking bench: a behavioural stack answers the strobes, and a queue
// model predicts the per-cycle strobe/result timeline of every operation.
module tb_stack_op_sequencer;

  localparam int DW    = 8;
  localparam int DEPTH = 32;

  localparam logic [2:0] S_NONE = 3'b000;
  localparam logic [2:0] S_PUSH = 3'b100;
  localparam logic [2:0] S_POP  = 3'b010;
  localparam logic [2:0] S_TOS  = 3'b001;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          op_valid = 1'b0;
  logic [2:0]    op_code = 3'd0;
  logic [DW-1:0] op_imm = '0;
  logic          op_ready, push, pop, tos, res_valid, err;
  logic [DW-1:0] stk_din, res_data;
  logic [DW-1:0] stk_res = '0;
  logic [5:0]    depth;

  int checks = 0;
  int failures = 0;
  int op_num = 0;

  always #5 clk = ~clk;

  stack_op_sequencer #(.DATA_W(DW), .STK_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op_code   (op_code),
    .op_imm    (op_imm),
    .op_ready  (op_ready),
    .push      (push),
    .pop       (pop),
    .tos       (tos),
    .stk_din   (stk_din),
    .stk_res   (stk_res),
    .res_valid (res_valid),
    .res_data  (res_data),
    .err       (err),
    .depth     (depth)
  );

  // Downstream stack: registers the top on pop/tos, reset with the system.
  logic [DW-1:0] mem [0:63];
  int            ptr = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      ptr <= 0;
    end else if (push) begin
      if (ptr < 64) mem[ptr] <= stk_din;
      ptr <= ptr + 1;
    end else if (pop) begin
      if (ptr > 0) begin
        stk_res <= mem[ptr-1];
        ptr     <= ptr - 1;
      end
    end else if (tos) begin
      if (ptr > 0) stk_res <= mem[ptr-1];
    end
  end

  // Reference model state.
  logic [DW-1:0] ref_q[$];
  logic          ref_err;
  logic [DW-1:0] last_res;

  task automatic apply_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    op_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({push, pop, tos} !== 3'b000 || res_valid !== 1'b0 || op_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ctrl got push/pop/tos=%b res_valid=%b op_ready=%b exp 000/0/1",
               {push, pop, tos}, res_valid, op_ready);
    end
    checks++;
    if (stk_din !== 8'h00 || res_data !== 8'h00 || err !== 1'b0 || depth !== 6'd0) begin
      failures++;
      $display("FAIL reset_data got stk_din=%h res_data=%h err=%b depth=%0d exp 00/00/0/0",
               stk_din, res_data, err, depth);
    end
    rst_n = 1'b1;
    ref_q.delete();
    ref_err  = 1'b0;
    last_res = '0;
  endtask

  // Issue one op (DUT is expected ready now) and check every cycle until ready again.
  task automatic do_op(input logic [2:0] code, input logic [DW-1:0] imm);
    int            lat;
    int            res_cyc;
    logic [DW-1:0] res_val;
    logic [2:0]    exp_s [1:6];
    logic [DW-1:0] exp_d [1:6];
    logic [DW-1:0] a, b, r;

    op_num++;
    lat = 1;
    res_cyc = 0;
    res_val = '0;
    for (int k = 1; k <= 6; k++) begin
      exp_s[k] = S_NONE;
      exp_d[k] = '0;
    end

    case (code)
      3'd0: ;
      3'd1: begin
        if (ref_q.size() == DEPTH) ref_err = 1'b1;
        else begin
          ref_q.push_back(imm);
          exp_s[1] = S_PUSH; exp_d[1] = imm; lat = 2;
        end
      end
      3'd2, 3'd3: begin
        if (ref_q.size() == 0) ref_err = 1'b1;
        else begin
          res_val = ref_q[$];
          if (code == 3'd2) void'(ref_q.pop_back());
          exp_s[1] = (code == 3'd2) ? S_POP : S_TOS;
          res_cyc = 3; lat = 3;
        end
      end
      3'd7: begin
        if (ref_q.size() == 0) ref_err = 1'b1;
        else begin
          a = ref_q.pop_back();
          r = ~a;
          ref_q.push_back(r);
          exp_s[1] = S_POP; exp_s[3] = S_PUSH; exp_d[3] = r;
          res_cyc = 4; res_val = r; lat = 4;
        end
      end
      default: begin
        if (ref_q.size() < 2) ref_err = 1'b1;
        else begin
          a = ref_q.pop_back();
          b = ref_q.pop_back();
          if (code == 3'd4)      r = b + a;
          else if (code == 3'd5) r = b - a;
          else                   r = b & a;
          ref_q.push_back(r);
          exp_s[1] = S_POP; exp_s[3] = S_POP; exp_s[5] = S_PUSH; exp_d[5] = r;
          res_cyc = 6; res_val = r; lat = 6;
        end
      end
    endcase

    op_valid = 1'b1;
    op_code  = code;
    op_imm   = imm;
    @(posedge clk);
    #1;
    // Offer junk while busy; it must be ignored.
    op_valid = (lat > 1);
    op_code  = 3'($urandom);
    op_imm   = DW'($urandom);

    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      checks++;
      if ({push, pop, tos} !== exp_s[k]) begin
        failures++;
        $display("FAIL op%0d code=%0d strobe cyc%0d got=%b exp=%b", op_num, code, k, {push, pop, tos}, exp_s[k]);
      end
      if (exp_s[k] == S_PUSH) begin
        checks++;
        if (stk_din !== exp_d[k]) begin
          failures++;
          $display("FAIL op%0d code=%0d stk_din cyc%0d got=%h exp=%h", op_num, code, k, stk_din, exp_d[k]);
        end
      end
      checks++;
      if (op_ready !== (k == lat)) begin
        failures++;
        $display("FAIL op%0d code=%0d op_ready cyc%0d got=%b exp=%b", op_num, code, k, op_ready, (k == lat));
      end
      checks++;
      if (res_valid !== (k == res_cyc)) begin
        failures++;
        $display("FAIL op%0d code=%0d res_valid cyc%0d got=%b exp=%b", op_num, code, k, res_valid, (k == res_cyc));
      end
      if (k == res_cyc) last_res = res_val;
      checks++;
      if (res_data !== last_res) begin
        failures++;
        $display("FAIL op%0d code=%0d res_data cyc%0d got=%h exp=%h", op_num, code, k, res_data, last_res);
      end
      op_valid = (k < lat) ? 1'($urandom) : 1'b0;
    end

    checks++;
    if (depth !== 6'(ref_q.size()) || err !== ref_err) begin
      failures++;
      $display("FAIL op%0d code=%0d end_state got depth=%0d err=%b exp depth=%0d err=%b",
               op_num, code, depth, err, ref_q.size(), ref_err);
    end
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_add();
    apply_reset();
    do_op(3'd1, 8'd5);
    do_op(3'd1, 8'd3);
    do_op(3'd4, 8'd0);
    checks++;
    if (res_data !== 8'd8 || depth !== 6'd1 || err !== 1'b0) begin
      failures++;
      $display("FAIL add_result got res=%h depth=%0d err=%b exp 08/1/0", res_data, depth, err);
    end
  endtask

  task automatic test_sub();
    apply_reset();
    do_op(3'd1, 8'd3);
    do_op(3'd1, 8'd5);
    do_op(3'd5, 8'd0);
    checks++;
    if (res_data !== 8'hFE || depth !== 6'd1) begin
      failures++;
      $display("FAIL sub_result got res=%h depth=%0d exp fe/1", res_data, depth);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 33; i++) do_op(3'd1, DW'($urandom));
    checks++;
    if (depth !== 6'd32 || err !== 1'b1) begin
      failures++;
      $display("FAIL overflow got depth=%0d err=%b exp 32/1", depth, err);
    end
  endtask

  task automatic test_underflow();
    apply_reset();
    do_op(3'd2, 8'd0);
    do_op(3'd1, 8'hA5);
    do_op(3'd3, 8'd0);
    checks++;
    if (res_data !== 8'hA5 || depth !== 6'd1 || err !== 1'b1) begin
      failures++;
      $display("FAIL underflow_tos got res=%h depth=%0d err=%b exp a5/1/1", res_data, depth, err);
    end
    do_op(3'd6, 8'd0);
  endtask

  task automatic test_not();
    apply_reset();
    do_op(3'd1, 8'h0F);
    do_op(3'd7, 8'd0);
    checks++;
    if (res_data !== 8'hF0) begin
      failures++;
      $display("FAIL not_result got=%h exp=f0", res_data);
    end
  endtask

  task automatic test_reset_mid_op();
    apply_reset();
    do_op(3'd2, 8'd0);
    do_op(3'd1, 8'd5);
    do_op(3'd1, 8'd3);
    op_valid = 1'b1;
    op_code  = 3'd4;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (pop !== 1'b1) begin
      failures++;
      $display("FAIL midreset_second_pop got=%b exp=1", pop);
    end
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rst_n = 1'b1;
      checks++;
      if ({push, pop, tos} !== 3'b000 || depth !== 6'd0 || err !== 1'b0 || op_ready !== 1'b1) begin
        failures++;
        $display("FAIL midreset cyc%0d got strobes=%b depth=%0d err=%b ready=%b exp 000/0/0/1",
                 k, {push, pop, tos}, depth, err, op_ready);
      end
    end
    ref_q.delete();
    ref_err  = 1'b0;
    last_res = '0;
    do_op(3'd1, 8'h3C);
    do_op(3'd2, 8'd0);
  endtask

  task automatic test_back_to_back_random();
    logic [2:0] code;
    apply_reset();
    for (int i = 0; i < 200; i++) begin
      code = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) code = 3'd1;
      do_op(code, DW'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_underflow();
    test_not();
    test_reset_mid_op();
    test_back_to_back_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stack_op_sequencer.md
STACK_OP_SEQUENCER -- requirements
Module: stack_op_sequencer

Interface
REQ-001 Parameter DATA_W, default 8, operand/result width.
REQ-002 Parameter STK_DEPTH, default 32, capacity of the stack it drives.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 op_valid  input  1  operation offered.
REQ-006 op_code  input  3  operation select, see REQ-013.
REQ-007 op_imm  input  DATA_W  immediate for PUSHI.
REQ-008 op_ready  output  1  sequencer can accept an operation.
REQ-009 push / pop / tos  output  1 each  single-cycle strobes to downstream stack.
REQ-010 stk_din  output  DATA_W  data to stack, meaningful only while push=1.
REQ-011 stk_res  input  DATA_W  stack output; holds the value registered by the stack on the edge that ended a pop/tos cycle.
REQ-012 res_valid  output  1  one-cycle pulse; res_data  output  DATA_W; err  output  1  sticky error; depth  output  6  current entry count.

Function
REQ-013 Opcodes: 000 NOP, 001 PUSHI, 010 POP, 011 TOS, 100 ADD, 101 SUB, 110 AND, 111 NOT.
REQ-014 op_ready=1 only in IDLE; an op is accepted on an edge with op_valid=1 and op_ready=1 (accept cycle T); op_code/op_imm registered at acceptance.
REQ-015 At most one of push/pop/tos is high in any cycle; each strobe is exactly one cycle.
REQ-016 FSM states: IDLE, STROBE1, CAP1, STROBE2, CAP2, PUSH_R, REPORT.
REQ-017 NOP: no strobes, no res_valid, op_ready=1 again at T+1.
REQ-018 PUSHI: push=1, stk_din=op_imm at T+1; depth+1; op_ready at T+2; no res_valid.
REQ-019 POP: pop=1 at T+1; stk_res captured at T+2; res_valid=1, res_data=captured at T+3; op_ready at T+3; depth-1.
REQ-020 TOS: as POP but strobe is tos; depth unchanged.
REQ-021 ADD/SUB/AND: pop T+1, capture A (top) T+2, pop T+3, capture B T+4, push T+5 with stk_din=result, res_valid+res_data=result at T+6, op_ready at T+6; net depth-1.
REQ-022 Results: ADD=B+A, SUB=B-A, AND=B&A, all modulo 2^DATA_W, no carry/borrow output.
REQ-023 NOT: pop T+1, capture T+2, push ~A T+3, res_valid+res_data T+4, op_ready T+4; depth unchanged.
REQ-024 Overflow: PUSHI with depth=STK_DEPTH -> no strobe, err set, depth unchanged, op_ready at T+1.
REQ-025 Underflow: POP/TOS/NOT with depth=0, or binary op with depth<2 -> no strobe, err set, no res_valid, op_ready at T+1.
REQ-026 Legal boundary: PUSHI at depth=STK_DEPTH-1 reaches STK_DEPTH without error; binary op at depth=2 completes to depth=1.
REQ-027 err is sticky; cleared only by reset; later legal ops still execute normally.
REQ-028 op_valid while op_ready=0 is ignored; the offered op must be held by the producer.
REQ-029 res_data holds last result between pulses.

Reset
REQ-030 On rst_n=0 at an edge: state=IDLE, push=pop=tos=0, stk_din=0, res_valid=0, res_data=0, err=0, depth=0, op_ready=1 in the following cycle.
REQ-031 Reset mid-operation abandons it with no further strobes; the stack shall be reset on the same edge by the system.

Structure
REQ-032 Shared package stack_pkg holds DATA_W default, STK_DEPTH, opcode constants and FSM state encoding.
REQ-033 One combinational sub-module stack_alu (op, A, B -> result) implements REQ-022 and NOT.

Verification
REQ-034 Reset; PUSHI 5, PUSHI 3, ADD -> push of 8 at ADD T+5, res_data=8, depth=1, err=0.
REQ-035 PUSHI 3, PUSHI 5, SUB -> result 0xFE (3-5 mod 256), depth=1.
REQ-036 33 PUSHIs from reset -> first 32 strobe push, depth=32; 33rd no push, err=1, depth=32.
REQ-037 POP at depth=0 after reset -> no pop strobe, err=1, op_ready at T+1; then PUSHI 0xA5, TOS -> res_data=0xA5, depth=1.
REQ-038 PUSHI 0x0F, NOT -> push 0xF0 at T+3, res_valid at T+4.
REQ-039 Assert rst_n=0 at ADD T+3 -> no strobe after, depth=0, err=0, op_ready=1 next cycle.
